fifo_uart_tx: RTL and testbench

Serial transmitter that drains the read side of the async FIFO and shifts each word out as an asynchronous UART frame. Sits directly downstream of the FIFO in the read clock domain: it watches `rempty`, samples the fall-through `rdata`, and pulses `rinc` once per word. Frame format and bit period are set by parameters.

---
 rtl/uart_pkg.sv | 13 +
 rtl/fifo_uart_tx_baud_tick.sv | 18 +
 rtl/fifo_uart_tx.sv | 97 +++++++++
 tb/tb_fifo_uart_tx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and parity mode constants for the FIFO-fed UART transmitter.
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// baud_tick: bit-period counter; tick pulses on the last rclk cycle of each bit.
// Ports: rclk/rrst (async high reset), clear restarts the period, tick marks the bit boundary.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic rclk,
    input  logic rrst,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q;
    assign tick = cnt_q == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) cnt_q <= '0;
        else      cnt_q <= (clear || tick) ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a fall-through FIFO read port and serialises each word as a UART frame.
// Ports: rclk/rrst (async high reset); rdata/rempty from the FIFO, rinc pop strobe back to it;
// enable gates new frames; txd serial line (idle high); busy high while a frame is on the line.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATASIZE     = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOPBITS     = 1
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [DATASIZE-1:0] rdata,
    input  logic                rempty,
    output logic                rinc,
    input  logic                enable,
    output logic                txd,
    output logic                busy
);
    localparam int BW = $clog2(DATASIZE + 1);
    state_t              state_q;
    logic [DATASIZE-1:0] shift_q;
    logic [BW-1:0]       bit_q;
    logic                stop_q, par_q, txd_q, busy_q;
    logic                tick, last_stop, pop;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .rclk  (rclk),
        .rrst  (rrst),
        .clear (pop),
        .tick  (tick)
    );

    // A pop is allowed from IDLE or on the very last stop cycle, which makes streaming gapless.
    always_comb begin
        last_stop = (STOPBITS == 1) || stop_q;
        pop = enable && !rempty &&
              (state_q == ST_IDLE || (state_q == ST_STOP && tick && last_stop));
    end

    assign rinc = pop;
    assign txd  = txd_q;
    assign busy = busy_q;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else if (pop) begin
            state_q <= ST_START;
            shift_q <= rdata;
            par_q   <= (PARITY == PAR_EVEN) ? ^rdata : ~^rdata;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else if (tick) begin
            case (state_q)
                ST_START: begin
                    state_q <= ST_DATA;
                    txd_q   <= shift_q[0];
                end
                ST_DATA: begin
                    if (bit_q == BW'(DATASIZE - 1)) begin
                        bit_q   <= '0;
                        state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        txd_q   <= (PARITY != PAR_NONE) ? par_q : 1'b1;
                    end else begin
                        bit_q   <= bit_q + 1'b1;
                        shift_q <= shift_q >> 1;
                        txd_q   <= shift_q[1];
                    end
                end
                ST_PARITY: begin
                    state_q <= ST_STOP;
                    txd_q   <= 1'b1;
                end
                ST_STOP: begin
                    if (last_stop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        txd_q   <= 1'b1;
                    end else begin
                        stop_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of framing, parity, streaming, enable and reset behaviour.
module tb_fifo_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] rdata = 8'h00;
    logic       rempty = 1'b1;
    logic       rinc, txd, busy;
    logic       rempty_p = 1'b1;
    logic [7:0] rdata_p = 8'h07;
    logic       rinc_e, txd_e, busy_e, rinc_o, txd_o, busy_o;
    logic [7:0] fifo[$];
    int         pops = 0;
    int         checks = 0;
    int         errors = 0;
    logic [10:0] exp_e = 11'b11000001110;
    logic [10:0] exp_o = 11'b10000001110;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(4), .PARITY(0), .STOPBITS(1)) dut (
        .rclk(clk), .rrst(rst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .enable(enable), .txd(txd), .busy(busy));
    fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(4), .PARITY(2), .STOPBITS(1)) dut_e (
        .rclk(clk), .rrst(rst), .rdata(rdata_p), .rempty(rempty_p), .rinc(rinc_e),
        .enable(1'b1), .txd(txd_e), .busy(busy_e));
    fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(4), .PARITY(1), .STOPBITS(1)) dut_o (
        .rclk(clk), .rrst(rst), .rdata(rdata_p), .rempty(rempty_p), .rinc(rinc_o),
        .enable(1'b1), .txd(txd_o), .busy(busy_o));

    // FIFO read-side model: registered empty flag and fall-through head word.
    always @(posedge clk) begin
        if (rinc) begin
            pops++;
            if (fifo.size() > 0) fifo.delete(0);
        end
        rempty <= fifo.size() == 0;
        rdata  <= fifo.size() > 0 ? fifo[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rinc(input string tag);
        int n = 0;
        #1;
        while (!rinc && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(rinc), 1);
    endtask

    // Starts in the pop cycle; checks every cycle of a 40-cycle 8N1 frame of word w.
    task automatic check_frame(input string tag, input logic [7:0] w, input int drop_at,
                               input logic last_rinc);
        logic [9:0] bits;
        bits = {1'b1, w, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == drop_at) enable = 1'b0;
            chk({tag, "_txd"}, 32'(txd), 32'(bits[i/4]));
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_rinc"}, 32'(rinc), (i == 39) ? 32'(last_rinc) : 0);
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_idle_txd"}, 32'(txd), 1);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        @(negedge clk);
        chk("reset_txd", 32'(txd), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rinc", 32'(rinc), 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("empty_rinc", 32'(rinc), 0);
            chk("empty_txd", 32'(txd), 1);
            chk("empty_busy", 32'(busy), 0);
        end
        rempty_p = 1'b0;
        #1;
        chk("par_rinc_e", 32'(rinc_e), 1);
        chk("par_rinc_o", 32'(rinc_o), 1);
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (i == 0) rempty_p = 1'b1;
            chk("par_even_txd", 32'(txd_e), 32'(exp_e[i/4]));
            chk("par_odd_txd", 32'(txd_o), 32'(exp_o[i/4]));
            chk("par_even_busy", 32'(busy_e), 1);
            chk("par_odd_busy", 32'(busy_o), 1);
        end
        @(negedge clk);
        chk("par_end_busy_e", 32'(busy_e), 0);
        chk("par_end_busy_o", 32'(busy_o), 0);
        chk("par_end_txd_e", 32'(txd_e), 1);
        fifo.push_back(8'hA5);
        wait_rinc("a5_pop");
        check_frame("a5", 8'hA5, -1, 1'b0);
        check_idle("a5");
        chk("a5_pops", 32'(pops), 1);
        fifo.push_back(8'h00);
        fifo.push_back(8'hFF);
        wait_rinc("s0_pop");
        check_frame("s0", 8'h00, -1, 1'b1);
        check_frame("s1", 8'hFF, -1, 1'b0);
        check_idle("s1");
        chk("stream_pops", 32'(pops), 3);
        fifo.push_back(8'h3C);
        fifo.push_back(8'h55);
        wait_rinc("en_pop");
        check_frame("en", 8'h3C, 10, 1'b0);
        check_idle("en");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("en_hold_rinc", 32'(rinc), 0);
            chk("en_hold_busy", 32'(busy), 0);
        end
        chk("en_pops", 32'(pops), 4);
        chk("en_rempty", 32'(rempty), 0);
        enable = 1'b1;
        wait_rinc("rs_pop");
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rs_txd", 32'(txd), 1);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_rinc", 32'(rinc), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rs_pops_lost", 32'(pops), 5);
        fifo.push_back(8'h96);
        wait_rinc("rs2_pop");
        check_frame("rs2", 8'h96, -1, 1'b0);
        check_idle("rs2");
        chk("rs_pops", 32'(pops), 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
